itype_issue_wb: RTL and testbench

Issue and writeback stage for the single-cycle core's OP-IMM path. It accepts a fetched instruction over a valid/ready handshake and decodes/validates the I-type fields. It reads rs1 from an internal 32x32 register file and drives the I-type execute bus (idata, rv1, imm). It then captures regdata_I and writes the result back to rd, one instruction in flight at a time.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rv_regfile.sv | 29 ++
 rtl/itype_issue_wb.sv | 94 +++++++++
 tb/tb_itype_issue_wb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: OP-IMM encodings, issue FSM states and immediate helper
package riscv_pkg;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_ADDI     = 3'b000;
  localparam logic [2:0] F3_SLLI     = 3'b001;
  localparam logic [2:0] F3_SLTI     = 3'b010;
  localparam logic [2:0] F3_SLTIU    = 3'b011;
  localparam logic [2:0] F3_XORI     = 3'b100;
  localparam logic [2:0] F3_SRXI     = 3'b101;
  localparam logic [2:0] F3_ORI      = 3'b110;
  localparam logic [2:0] F3_ANDI     = 3'b111;
  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;
  typedef enum logic [1:0] {IDLE, EXEC, WB} issue_state_t;
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction
endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: register file, one sync write port, two comb read ports, x0 reads zero
module rv_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);
  logic [XLEN-1:0] regs_q [NREGS];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end
  always_comb begin
    rdata_a_o = raddr_a_i == '0 ? '0 : regs_q[raddr_a_i];
    rdata_b_o = raddr_b_i == '0 ? '0 : regs_q[raddr_b_i];
  end
endmodule

// File: rtl/itype_issue_wb.sv
// itype_issue_wb: OP-IMM issue/writeback, one instruction in flight (IDLE -> EXEC -> WB)
module itype_issue_wb
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [31:0]     idata,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] regdata_I,
  output logic            retire,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  issue_state_t    state_q, state_d;
  logic [31:0]     idata_q;
  logic [XLEN-1:0] rv1_q, imm_q, result_q, retire_data_q, rs1_data;
  logic [4:0]      retire_rd_q;
  logic            retire_q, illegal_q, fire, legal;
  logic [6:0]      f7;
  logic [2:0]      f3;

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (state_q == WB),
    .waddr_i   (idata_q[11:7]),
    .wdata_i   (result_q),
    .raddr_a_i (instr[19:15]),
    .rdata_a_o (rs1_data),
    .raddr_b_i (dbg_raddr),
    .rdata_b_o (dbg_rdata)
  );

  always_comb begin
    f7 = instr[31:25];
    f3 = instr[14:12];
    instr_ready = state_q == IDLE;
    fire = instr_valid && instr_ready;
    legal = instr[6:0] == OPC_OP_IMM &&
            (f3 == F3_SLLI ? f7 == FUNCT7_ZERO :
             f3 == F3_SRXI ? (f7 == FUNCT7_ZERO || f7 == FUNCT7_SRA) : 1'b1);
    state_d = state_q == IDLE ? (fire && legal ? EXEC : IDLE) :
              state_q == EXEC ? WB : IDLE;
  end

  // rs1 is read at accept: any earlier WB write has already landed by then
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idata_q       <= '0;
      rv1_q         <= '0;
      imm_q         <= '0;
      result_q      <= '0;
      retire_q      <= 1'b0;
      retire_rd_q   <= '0;
      retire_data_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= fire && !legal;
      retire_q  <= state_q == WB;
      if (fire && legal) begin
        idata_q <= instr;
        rv1_q   <= rs1_data;
        imm_q   <= sext12(instr[31:20]);
      end
      if (state_q == EXEC) result_q <= regdata_I;
      if (state_q == WB) begin
        retire_rd_q   <= idata_q[11:7];
        retire_data_q <= result_q;
      end
    end
  end

  always_comb begin
    idata       = idata_q;
    rv1         = rv1_q;
    imm         = imm_q;
    retire      = retire_q;
    retire_rd   = retire_rd_q;
    retire_data = retire_data_q;
    illegal     = illegal_q;
  end
endmodule

// File: tb/tb_itype_issue_wb.sv
// tb_itype_issue_wb: directed OP-IMM vectors with hand-computed results
module tb_itype_issue_wb;
  logic        clk = 1'b0;
  logic        rst_n, instr_valid, instr_ready, retire, illegal;
  logic [31:0] instr, idata, rv1, imm, regdata_I, retire_data, dbg_rdata;
  logic [4:0]  retire_rd, dbg_raddr;
  int          errors = 0, checks = 0;

  itype_issue_wb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .idata       (idata),
    .rv1         (rv1),
    .imm         (imm),
    .regdata_I   (regdata_I),
    .retire      (retire),
    .retire_rd   (retire_rd),
    .retire_data (retire_data),
    .illegal     (illegal),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1 check($sformatf("dbg_x%0d", r), dbg_rdata, exp);
  endtask

  task automatic run_legal(input logic [31:0] ins, input logic [31:0] e_rv1, input logic [31:0] e_imm,
                           input logic [31:0] res, input logic [4:0] rd);
    instr = ins;
    instr_valid = 1'b1;
    check("ready_idle", {31'b0, instr_ready}, 1);
    @(posedge clk) #1 instr_valid = 1'b0;
    regdata_I = res;
    @(negedge clk);
    check("exec_idata", idata, ins);
    check("exec_rv1", rv1, e_rv1);
    check("exec_imm", imm, e_imm);
    check("exec_ready", {31'b0, instr_ready}, 0);
    @(negedge clk);
    check("wb_ready", {31'b0, instr_ready}, 0);
    check("wb_retire", {31'b0, retire}, 0);
    regdata_I = 32'hDEAD_BEEF;
    @(negedge clk);
    check("retire", {31'b0, retire}, 1);
    check("retire_rd", {27'b0, retire_rd}, {27'b0, rd});
    check("retire_data", retire_data, res);
    check("retire_illegal", {31'b0, illegal}, 0);
    dbg(rd, rd == 5'd0 ? 32'd0 : res);
    @(negedge clk) check("retire_once", {31'b0, retire}, 0);
  endtask

  task automatic run_illegal(input logic [31:0] ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk) #1 instr_valid = 1'b0;
    @(negedge clk);
    check("illegal_pulse", {31'b0, illegal}, 1);
    check("illegal_ready", {31'b0, instr_ready}, 1);
    check("illegal_retire", {31'b0, retire}, 0);
    @(negedge clk);
    check("illegal_once", {31'b0, illegal}, 0);
    check("illegal_no_retire", {31'b0, retire}, 0);
  endtask

  logic [31:0] s_ins [3] = '{32'h0030_0293, 32'hFFE0_0313, 32'h4013_5393};
  logic [31:0] s_rv1 [3] = '{32'h0, 32'h0, 32'hFFFF_FFFE};
  logic [31:0] s_res [3] = '{32'h3, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
  logic [4:0]  s_rd  [3] = '{5'd5, 5'd6, 5'd7};

  initial begin
    int idx, nret;
    logic rdy;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; regdata_I = '0; dbg_raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 1);
    check("rst_retire", {31'b0, retire}, 0);
    check("rst_illegal", {31'b0, illegal}, 0);
    check("rst_idata", idata, 0);
    check("rst_rv1", rv1, 0);
    check("rst_imm", imm, 0);
    check("rst_retire_rd", {27'b0, retire_rd}, 0);
    check("rst_retire_data", retire_data, 0);
    dbg(5'd1, 32'd0);
    @(posedge clk) #1 rst_n = 1'b1;

    run_legal(32'h0050_0093, 32'd0, 32'd5, 32'd5, 5'd1);
    run_legal(32'hFFF0_8113, 32'd5, 32'hFFFF_FFFF, 32'd4, 5'd2);
    run_legal(32'h0070_0013, 32'd0, 32'd7, 32'd7, 5'd0);
    dbg(5'd0, 32'd0);

    run_illegal(32'h0020_81B3);
    run_illegal(32'h0210_9213);
    dbg(5'd3, 32'd0);
    dbg(5'd4, 32'd0);
    dbg(5'd1, 32'd5);
    dbg(5'd2, 32'd4);

    // valid held high across three back-to-back legal instructions
    @(posedge clk) #1;
    idx = 0; nret = 0;
    instr = s_ins[0]; instr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = instr_ready;
      check($sformatf("stream_ready_c%0d", c), {31'b0, rdy}, {31'b0, c % 3 == 0});
      check($sformatf("stream_retire_c%0d", c), {31'b0, retire}, {31'b0, c % 3 == 0 && c > 0});
      if (retire) begin
        nret++;
        check("stream_rd", {27'b0, retire_rd}, {27'b0, s_rd[c/3-1]});
        check("stream_data", retire_data, s_res[c/3-1]);
      end
      if (c % 3 == 1) begin
        check("stream_idata", idata, s_ins[c/3]);
        check("stream_rv1", rv1, s_rv1[c/3]);
        regdata_I = s_res[c/3];
      end
      @(posedge clk) #1;
      if (rdy && instr_valid) idx++;
      if (idx < 3) instr = s_ins[idx];
      else instr_valid = 1'b0;
    end
    check("stream_retire_count", nret, 3);
    dbg(5'd7, 32'hFFFF_FFFF);

    // reset while addi x5,x0,9 is in EXEC
    instr = 32'h0090_0293; instr_valid = 1'b1;
    @(posedge clk) #1 instr_valid = 1'b0;
    regdata_I = 32'd9;
    rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, instr_ready}, 1);
    check("rst_mid_retire", {31'b0, retire}, 0);
    check("rst_mid_idata", idata, 0);
    @(negedge clk);
    check("rst_mid_no_retire", {31'b0, retire}, 0);
    for (int r = 0; r < 32; r++) dbg(5'(r), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
